// File: rtl/aes_inv_key_schedule_if.sv
// aes_inv_key_schedule_if: load request and round-key stream of the inverse key schedule
interface aes_inv_key_schedule_if;
  logic start;
  logic [127:0] last_key;
  logic [127:0] rk;
  logic [3:0] rk_round;
  logic rk_valid;
  logic rk_ready;
  logic busy;
  logic done;
  modport master(output start, last_key, rk_ready, input rk, rk_round, rk_valid, busy, done);
  modport slave(input start, last_key, rk_ready, output rk, rk_round, rk_valid, busy, done);
endinterface

// File: rtl/aes_inv_key_schedule.sv
// aes_inv_key_schedule: iterative AES-128 inverse key expansion, emits round keys NR down to 0
module aes_inv_key_schedule #(parameter int NR = 10) (
  input logic clk,
  input logic rst_n,
  aes_inv_key_schedule_if.slave ks
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [0:15][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state;
  logic [31:0] p0, p1, p2, p3, rw;
  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction
  always_comb begin
    p3 = ks.rk[31:0] ^ ks.rk[63:32];
    p2 = ks.rk[63:32] ^ ks.rk[95:64];
    p1 = ks.rk[95:64] ^ ks.rk[127:96];
    rw = {p3[23:0], p3[31:24]};
    p0 = ks.rk[127:96] ^ {sb(rw[31:24]), sb(rw[23:16]), sb(rw[15:8]), sb(rw[7:0])} ^ {RCON[ks.rk_round], 24'h0};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ks.rk <= '0;
      ks.rk_round <= '0;
      ks.rk_valid <= 1'b0;
      ks.busy <= 1'b0;
      ks.done <= 1'b0;
    end else begin
      ks.done <= 1'b0;
      if (state == IDLE) begin
        if (ks.start) begin
          ks.rk <= ks.last_key;
          ks.rk_round <= 4'(NR);
          ks.rk_valid <= 1'b1;
          ks.busy <= 1'b1;
          state <= EMIT;
        end
      end else if (ks.rk_ready) begin
        if (ks.rk_round != 4'd0) begin
          ks.rk <= {p0, p1, p2, p3};
          ks.rk_round <= ks.rk_round - 4'd1;
        end else begin
          ks.rk_valid <= 1'b0;
          ks.busy <= 1'b0;
          ks.done <= 1'b1;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// tb_aes_inv_key_schedule: random and FIPS-197 keys checked against a forward key-expansion model
module tb_aes_inv_key_schedule;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [7:0] sbt [256];
  logic [127:0] exp_rk [11];
  aes_inv_key_schedule_if ks();
  aes_inv_key_schedule dut (.clk(clk), .rst_n(rst_n), .ks(ks.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = xt(a);
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction
  task automatic build_sbox();
    logic [7:0] inv;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, 8'(b));
      sbt[b] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask
  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]], sbt[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask
  // mode 0: ready held high; 1: ready pattern 1,0,0; 2: stray start during round 5
  task automatic run(input int mode);
    int r = 10;
    int cyc = 0;
    ks.start = 1'b1;
    ks.last_key = exp_rk[10];
    @(negedge clk);
    while (r >= 0 && cyc < 200) begin
      chk("valid", 128'(ks.rk_valid), 128'd1);
      chk("round", 128'(ks.rk_round), 128'(r));
      chk("rk", ks.rk, exp_rk[r]);
      chk("busy", 128'(ks.busy), 128'd1);
      chk("done_low", 128'(ks.done), 128'd0);
      ks.rk_ready = (mode == 1) ? (cyc % 3 == 0) : 1'b1;
      ks.start = (mode == 2 && r == 5);
      ks.last_key = (mode == 2 && r == 5) ? ~exp_rk[10] : exp_rk[10];
      @(negedge clk);
      if (ks.rk_ready) r--;
      cyc++;
    end
    ks.start = 1'b0;
    ks.rk_ready = 1'b1;
    chk("bounded", 128'(cyc < 200), 128'd1);
    chk("done", 128'(ks.done), 128'd1);
    chk("valid_end", 128'(ks.rk_valid), 128'd0);
    chk("busy_end", 128'(ks.busy), 128'd0);
    chk("rk_end", ks.rk, exp_rk[0]);
  endtask
  initial begin
    logic [127:0] k;
    ks.start = 1'b0;
    ks.last_key = '0;
    ks.rk_ready = 1'b1;
    build_sbox();
    repeat (2) @(negedge clk);
    chk("rst_rk", ks.rk, 128'd0);
    chk("rst_round", 128'(ks.rk_round), 128'd0);
    chk("rst_valid", 128'(ks.rk_valid), 128'd0);
    chk("rst_busy", 128'(ks.busy), 128'd0);
    chk("rst_done", 128'(ks.done), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("fips_r10", exp_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("fips_r9", exp_rk[9], 128'hac7766f319fadc2128d12941575c006e);
    run(0);
    @(negedge clk);
    chk("done_pulse", 128'(ks.done), 128'd0);
    chk("idle_valid", 128'(ks.rk_valid), 128'd0);
    chk("idle_rk_hold", ks.rk, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    run(1);
    @(negedge clk);
    run(2);
    @(negedge clk);
    ks.start = 1'b1;
    ks.last_key = exp_rk[10];
    @(negedge clk);
    ks.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_round", 128'(ks.rk_round), 128'd6);
    rst_n = 1'b0;
    #1;
    chk("async_rk", ks.rk, 128'd0);
    chk("async_round", 128'(ks.rk_round), 128'd0);
    chk("async_valid", 128'(ks.rk_valid), 128'd0);
    chk("async_busy", 128'(ks.busy), 128'd0);
    @(negedge clk);
    chk("reset_no_done", 128'(ks.done), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_done", 128'(ks.done), 128'd0);
    run(0);
    for (int n = 0; n < 1000; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      expand(k);
      run(n % 5 == 0 ? 1 : 0);
      chk("rand_key0", ks.rk, k);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
